div16by8_seq: RTL and testbench



---
 rtl/div_pkg.sv | 12 +
 rtl/div_restore_step.sv | 19 +
 rtl/div16by8_seq.sv | 97 +++++++++
 tb/tb_div16by8_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the sequential 16/8 restoring divider.
package div_pkg;
    localparam int DIV_DW    = 16;
    localparam int DIV_QW    = 8;
    localparam int DIV_ITERS = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } div_state_t;
endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_restore_step
    import div_pkg::*;
(
    input  logic [DIV_QW-1:0] partial,
    input  logic              msb_in,
    input  logic [DIV_QW-1:0] divisor,
    output logic [DIV_QW-1:0] partial_next,
    output logic              qbit
);
    logic [DIV_QW:0] t;
    logic [DIV_QW:0] diff;

    // The extra top bit keeps the compare exact when partial has its MSB set.
    assign t            = {partial, msb_in};
    assign diff         = t - {1'b0, divisor};
    assign qbit         = (t >= {1'b0, divisor});
    assign partial_next = qbit ? diff[DIV_QW-1:0] : t[DIV_QW-1:0];
endmodule

// File: rtl/div16by8_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per cycle,
// valid/ready request and response, error cases resolved at accept time.
module div16by8_seq
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int QW = DIV_QW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [QW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [QW-1:0] remainder,
    output logic          div_by_zero,
    output logic          overflow
);
    div_state_t    state, state_next;
    logic [2:0]    cnt;
    logic [QW-1:0] partial, shift, dvsr;
    logic [QW-1:0] partial_next;
    logic          qbit;
    logic          accept, err_dz, err_ov, last_step;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_ready && in_valid;
    // Divide-by-zero wins; a high byte >= divisor means the quotient needs more than QW bits.
    assign err_dz    = (divisor == '0);
    assign err_ov    = !err_dz && (dividend[DW-1:QW] >= divisor);
    assign last_step = (state == S_CALC) && (cnt == 3'(DIV_ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = (err_dz || err_ov) ? S_DONE : S_CALC;
            S_CALC:  if (last_step) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    div_restore_step u_step (
        .partial      (partial),
        .msb_in       (shift[QW-1]),
        .divisor      (dvsr),
        .partial_next (partial_next),
        .qbit         (qbit)
    );

    // Working registers carry no reset: they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            partial <= dividend[DW-1:QW];
            shift   <= dividend[QW-1:0];
            dvsr    <= divisor;
        end else if (state == S_CALC) begin
            partial <= partial_next;
            shift   <= {shift[QW-2:0], qbit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt <= '0;
        else if (accept)              cnt <= '0;
        else if (state == S_CALC)     cnt <= cnt + 3'd1;
    end

    // Results change only on an error accept or the final iteration, never mid-calculation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept && (err_dz || err_ov)) begin
            quotient    <= '1;
            remainder   <= '1;
            div_by_zero <= err_dz;
            overflow    <= err_ov;
        end else if (last_step) begin
            quotient    <= {shift[QW-2:0], qbit};
            remainder   <= partial_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div16by8_seq.sv
// Randomised self-checking bench for div16by8_seq against an arithmetic reference model.
module tb_div16by8_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  quotient, remainder;
    logic        div_by_zero, overflow;

    int n_cmp = 0;
    int n_fail = 0;

    div16by8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; error outcomes use all-ones results.
    function automatic logic [18:0] ref_div(input logic [15:0] dd, input logic [7:0] dv);
        int unsigned q, r;
        if (dv == 0) return {1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1};
        q = dd / dv;
        r = dd % dv;
        if (q > 255) return {1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1};
        return {1'b0, 1'b0, q[7:0], r[7:0], 1'b0};
    endfunction

    // Issue one request, wait for the response, capture it, then complete the handshake.
    // lat = rising edges from accept to out_valid; 99 means a bounded wait expired.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ov, output int lat);
        int guard = 0;
        q = 'x; r = 'x; dz = 'x; ov = 'x;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            lat = 99;
            return;
        end
        in_valid = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        if (!out_valid) begin
            lat = 99;
            return;
        end
        q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [15:0] dd, input logic [7:0] dv);
        logic [18:0] e;
        logic [7:0]  q, r;
        logic        dz, ov;
        int          lat, elat;
        e = ref_div(dd, dv);
        elat = e[0] ? 1 : 8;
        run_op(dd, dv, q, r, dz, ov, lat);
        n_cmp++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency %h/%h: got %0d expected %0d", name, dd, dv, lat, elat);
        end
        n_cmp++;
        if ({dz, ov, q, r} !== e[18:1]) begin
            n_fail++;
            $display("FAIL %s result %h/%h: got dz=%b ov=%b q=%h r=%h expected dz=%b ov=%b q=%h r=%h",
                     name, dd, dv, dz, ov, q, r, e[18], e[17], e[16:9], e[8:1]);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {2'b10, 18'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b expected rdy=1 rest 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        check_op("basic", 16'h1234, 8'h56);
        check_op("exact200x100", 16'h4E20, 8'h64);
        check_op("div_zero", 16'h0010, 8'h00);
        check_op("overflow", 16'h6400, 8'h64);
        check_op("max_nonov", 16'hFEFF, 8'hFF);
        check_op("zero_dividend", 16'h0000, 8'h01);
        check_op("ov_edge", 16'h0100, 8'h01);
    endtask

    task automatic test_exact_products();
        logic [7:0] a, b;
        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            if (i == 0) begin a = 8'hFF; b = 8'hFF; end
            check_op("exact", 16'(a * b), b);
        end
    endtask

    task automatic test_random();
        logic [7:0]  dv;
        logic [15:0] dd;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0:       begin dv = 8'h00; dd = 16'($urandom); end
                1:       begin dd = 16'($urandom); dv = 8'($urandom); end
                default: begin
                    dv = 8'($urandom_range(1, 255));
                    dd = 16'($urandom_range(0, dv * 256 - 1));
                end
            endcase
            check_op("random", dd, dv);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q0, r0;
        logic       dz0, ov0;
        int         guard = 0;
        @(negedge clk);
        in_valid = 1'b1; dividend = 16'h1234; divisor = 8'h56;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL bp_wait: out_valid=%b expected 1", out_valid);
        end
        q0 = quotient; r0 = remainder; dz0 = div_by_zero; ov0 = overflow;
        n_cmp++;
        if ({q0, r0, dz0, ov0} !== {8'h36, 8'h10, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_result: got q=%h r=%h expected q=36 r=10", q0, r0);
        end
        // A divide-by-zero request is offered while the response is stalled.
        in_valid = 1'b1; dividend = 16'h0010; divisor = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow}
                    !== {2'b10, q0, r0, dz0, ov0}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b q=%h r=%h dz=%b expected vld=1 rdy=0 q=%h r=%h dz=%b",
                         c, out_valid, in_ready, quotient, remainder, div_by_zero, q0, r0, dz0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_idle: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, div_by_zero, overflow, quotient, remainder} !== {4'b1010, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL bp_late_accept: got vld=%b rdy=%b dz=%b ov=%b q=%h r=%h expected vld=1 rdy=0 dz=1 ov=0 q=ff r=ff",
                     out_valid, in_ready, div_by_zero, overflow, quotient, remainder);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        in_valid = 1'b1; dividend = 16'h1234; divisor = 8'h56;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !== {2'b01, 18'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: got vld=%b rdy=%b q=%h r=%h dz=%b ov=%b expected vld=0 rdy=1 rest 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_op("after_reset", 16'h00FF, 8'h10);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_exact_products();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
